// File: rtl/rf_ddr_burst_packer_if.sv
// rf_ddr_burst_packer_if
//   Bundles the sample input, burst request and write-beat channels of the
//   RF-to-DDR burst packer.
//   slave  : packer view (consumes samples/acks/ready, drives request/beats)
//   master : environment view (sample source plus DDR AXI write master)
//   Ports:
//     enable, s_valid, s_data      sample capture (no backpressure)
//     burst_req, burst_addr        burst request, start byte address
//     burst_ack                    master accepts the request
//     wr_data, wr_valid, wr_last   write beats
//     wr_ready                     write beat ready
//     overflow, fill_level         sticky loss flag, FIFO occupancy in words
//     state_dbg                    FSM state (0 IDLE, 1 REQ, 2 DATA)
//   Handshake: a beat transfers on a rising edge where wr_valid && wr_ready;
//   while wr_valid=1 and wr_ready=0 the beat (wr_data/wr_last) holds stable.
//   A request is accepted on a rising edge where burst_req && burst_ack.
interface rf_ddr_burst_packer_if;
  logic        enable;
  logic        s_valid;
  logic [15:0] s_data;
  logic        burst_req;
  logic [31:0] burst_addr;
  logic        burst_ack;
  logic [31:0] wr_data;
  logic        wr_valid;
  logic        wr_ready;
  logic        wr_last;
  logic        overflow;
  logic [6:0]  fill_level;
  logic [1:0]  state_dbg;

  modport slave (
    input  enable, s_valid, s_data, burst_ack, wr_ready,
    output burst_req, burst_addr, wr_data, wr_valid, wr_last,
           overflow, fill_level, state_dbg
  );

  modport master (
    output enable, s_valid, s_data, burst_ack, wr_ready,
    input  burst_req, burst_addr, wr_data, wr_valid, wr_last,
           overflow, fill_level, state_dbg
  );
endinterface

// File: rtl/rf_ddr_burst_packer.sv
// rf_ddr_burst_packer
//   Packs pairs of 16-bit RF samples into 32-bit words, queues them in a word
//   FIFO and hands fixed-length bursts to a DDR AXI write master that writes
//   into a ring buffer.
//   Ports:
//     ACLK     single clock, rising edge
//     ARESETN  synchronous active-low reset
//     bus      rf_ddr_burst_packer_if.slave (sample, request, beat channels)
module rf_ddr_burst_packer #(
  parameter logic [31:0] C_BASE_ADDR  = 32'h0000_0000,
  parameter logic [31:0] C_RING_BYTES = 32'h0010_0000,
  parameter int          C_BURST_LEN  = 16,
  parameter int          C_FIFO_DEPTH = 64
) (
  input  logic                 ACLK,
  input  logic                 ARESETN,
  rf_ddr_burst_packer_if.slave bus
);

  localparam int PTR_W  = $clog2(C_FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BEAT_W = $clog2(C_BURST_LEN);
  localparam logic [CNT_W-1:0]  DEPTH     = CNT_W'(C_FIFO_DEPTH);
  localparam logic [CNT_W-1:0]  BURST     = CNT_W'(C_BURST_LEN);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(C_BURST_LEN - 1);
  localparam logic [31:0]       RING_END  = C_BASE_ADDR + C_RING_BYTES;

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DATA = 2'd2} state_t;
  state_t state, state_nxt;

  logic              half_valid;
  logic [15:0]       half_data;
  logic              word_pend;
  logic [31:0]       word_data;
  logic [31:0]       mem [C_FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [BEAT_W-1:0] beat;
  logic [31:0]       addr, addr_inc;
  logic              overflow_q;
  logic              pop, full, push, drop, last_hs;
  logic              req_c, valid_c;
  logic [31:0]       data_c;

  assign pop      = (state == DATA) && bus.wr_ready;
  assign full     = (count == DEPTH);
  // A pop in the same cycle frees the slot, so a word arriving at full is kept.
  assign push     = word_pend && (!full || pop);
  assign drop     = word_pend && full && !pop;
  assign last_hs  = pop && (beat == LAST_BEAT);
  assign addr_inc = addr + 32'd64;

  // Sample packer: a completed word is registered and pushed the next cycle.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      half_valid <= 1'b0;
      half_data  <= '0;
      word_pend  <= 1'b0;
      word_data  <= '0;
    end else begin
      word_pend <= 1'b0;
      if (!bus.enable) begin
        half_valid <= 1'b0;
      end else if (bus.s_valid) begin
        if (half_valid) begin
          word_data  <= {bus.s_data, half_data};
          word_pend  <= 1'b1;
          half_valid <= 1'b0;
        end else begin
          half_data  <= bus.s_data;
          half_valid <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESETN && push) mem[wr_ptr] <= word_data;
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (drop)             overflow_q <= 1'b1;
      else if (!bus.enable) overflow_q <= 1'b0;
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state <= IDLE;
      beat  <= '0;
      addr  <= C_BASE_ADDR;
    end else begin
      state <= state_nxt;
      if (pop) beat <= last_hs ? '0 : beat + BEAT_W'(1);
      if (last_hs) addr <= (addr_inc == RING_END) ? C_BASE_ADDR : addr_inc;
    end
  end

  // Entering DATA requires a full burst in the FIFO, and only DATA pops, so
  // the burst can never underrun once acked.
  always_comb begin
    state_nxt = state;
    req_c     = 1'b0;
    valid_c   = 1'b0;
    data_c    = '0;
    case (state)
      IDLE: if (count >= BURST) state_nxt = REQ;
      REQ: begin
        req_c = 1'b1;
        if (bus.burst_ack) state_nxt = DATA;
      end
      DATA: begin
        valid_c = 1'b1;
        data_c  = mem[rd_ptr];
        if (last_hs) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.burst_req  = req_c;
  assign bus.burst_addr = addr;
  assign bus.wr_valid   = valid_c;
  assign bus.wr_data    = data_c;
  assign bus.wr_last    = valid_c && (beat == LAST_BEAT);
  assign bus.overflow   = overflow_q;
  assign bus.fill_level = 7'(count);
  assign bus.state_dbg  = state;

endmodule
